// File: rtl/count_pkg.sv
// Shared types for the count sequencer: FSM state encoding.
// Pause/HOLD support is enabled by defining COUNT_SEQ_PAUSE_EN.
package count_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/count_core.sv
// WIDTH-bit up counter datapath: clear beats hold, hold beats enable.
// Async active-high reset.
module count_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic             hold,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clear) begin
            q_d = '0;
        end else if (!hold && en) begin
            q_d = q_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/count_seq_ctrl.sv
// Sequencing FSM around count_core: start/stop, auto-reload, done, wrap count.
// Define COUNT_SEQ_PAUSE_EN to add the pause port and HOLD state.
module count_seq_ctrl
    import count_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              auto_reload,
    input  logic [WIDTH-1:0]  limit,
`ifdef COUNT_SEQ_PAUSE_EN
    input  logic              pause,
`endif
    output logic [WIDTH-1:0]  out,
    output logic              busy,
    output logic              done,
    output logic [WRAP_W-1:0] wrap_cnt
);

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    limit_q, limit_d;
    logic                reload_q, reload_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic [WRAP_W-1:0]   wrap_q, wrap_d;
    logic                clr, en, at_lim;

    assign at_lim = (out == limit_q);

    always_comb begin
        state_d  = state_q;
        limit_d  = limit_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        wrap_d   = wrap_q;
        clr      = 1'b0;
        en       = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    limit_d  = limit;
                    reload_d = auto_reload;
                    wrap_d   = '0;
                    clr      = 1'b1;
                    if (limit == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
`ifdef COUNT_SEQ_PAUSE_EN
                end else if (pause) begin
                    state_d = HOLD;
`endif
                end else if (at_lim) begin
                    done_d = 1'b1;
                    if (reload_q) begin
                        clr    = 1'b1;
                        wrap_d = (&wrap_q) ? wrap_q : wrap_q + WRAP_W'(1);
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    en = 1'b1;
                end
            end
`ifdef COUNT_SEQ_PAUSE_EN
            HOLD: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (!pause) begin
                    state_d = RUN;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN) || (state_d == HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            limit_q  <= '0;
            reload_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            wrap_q   <= '0;
        end else begin
            state_q  <= state_d;
            limit_q  <= limit_d;
            reload_q <= reload_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            wrap_q   <= wrap_d;
        end
    end

    // Stop freezes the count even if it coincides with the terminal value.
    count_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk  (clk),
        .rst  (rst),
        .clear(clr),
        .en   (en),
        .hold (stop),
        .q    (out)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign wrap_cnt = wrap_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Scoreboard bench for count_seq_ctrl: per-cycle stimulus and expectations.
module tb_count_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       auto_reload;
    logic [3:0] limit;
`ifdef COUNT_SEQ_PAUSE_EN
    logic       pause;
`endif
    logic [3:0] out;
    logic       busy;
    logic       done;
    logic [7:0] wrap_cnt;

    int tests;
    int fails;

    typedef struct {
        logic       st;
        logic       sp;
        logic       ps;
        logic [3:0] lim;
        logic       ar;
    } stim_t;

    typedef struct {
        logic [3:0] o;
        logic       b;
        logic       d;
        logic [7:0] w;
    } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];

    count_seq_ctrl #(
        .WIDTH (4),
        .WRAP_W(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .auto_reload(auto_reload),
        .limit      (limit),
`ifdef COUNT_SEQ_PAUSE_EN
        .pause      (pause),
`endif
        .out        (out),
        .busy       (busy),
        .done       (done),
        .wrap_cnt   (wrap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic st, input logic sp, input logic ps,
                       input logic [3:0] lim, input logic ar,
                       input logic [3:0] o, input logic b, input logic d,
                       input logic [7:0] w);
        stim_t s;
        exp_t  e;
        s.st = st; s.sp = sp; s.ps = ps; s.lim = lim; s.ar = ar;
        e.o = o; e.b = b; e.d = d; e.w = w;
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic apply(input stim_t s);
        start       = s.st;
        stop        = s.sp;
        limit       = s.lim;
        auto_reload = s.ar;
`ifdef COUNT_SEQ_PAUSE_EN
        pause       = s.ps;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 0; stop = 0; limit = 0; auto_reload = 0;
`ifdef COUNT_SEQ_PAUSE_EN
        pause = 0;
`endif
        #10 rst = 1'b0;
        #1;
        tests++;
        if ({out, busy, done, wrap_cnt} !== 14'd0) begin
            fails++;
            $display("FAIL reset: out=%0d busy=%b done=%b wrap=%0d want all 0",
                     out, busy, done, wrap_cnt);
        end
    endtask

    task automatic test_oneshot();
        stim_t s;
        exp_t  e;
        int    c;
        add(1, 0, 0, 5, 0, 0, 1, 0, 0);
        for (int k = 1; k <= 5; k++) add(0, 0, 0, 5, 0, 4'(k), 1, 0, 0);
        add(0, 0, 0, 5, 0, 5, 0, 1, 0);
        add(0, 0, 0, 5, 0, 5, 0, 0, 0);
        add(0, 0, 0, 5, 0, 5, 0, 0, 0);
        c = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            apply(s);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            tests++;
            if ({out, busy, done, wrap_cnt} !== {e.o, e.b, e.d, e.w}) begin
                fails++;
                $display("FAIL oneshot c%0d: got o=%0d b=%b d=%b w=%0d want o=%0d b=%b d=%b w=%0d",
                         c, out, busy, done, wrap_cnt, e.o, e.b, e.d, e.w);
            end
            c++;
        end
    endtask

    task automatic test_reload();
        stim_t s;
        exp_t  e;
        int    c;
        add(1, 0, 0, 3, 1, 0, 1, 0, 0);
        for (int k = 1; k <= 20; k++)
            add(0, 0, 0, 3, 1, 4'(k % 4), 1, (k % 4 == 0), 8'(k / 4));
        add(0, 1, 0, 3, 1, 0, 0, 0, 5);
        add(0, 0, 0, 3, 1, 0, 0, 0, 5);
        c = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            apply(s);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            tests++;
            if ({out, busy, done, wrap_cnt} !== {e.o, e.b, e.d, e.w}) begin
                fails++;
                $display("FAIL reload c%0d: got o=%0d b=%b d=%b w=%0d want o=%0d b=%b d=%b w=%0d",
                         c, out, busy, done, wrap_cnt, e.o, e.b, e.d, e.w);
            end
            c++;
        end
    endtask

    task automatic test_stop();
        stim_t s;
        exp_t  e;
        int    c;
        add(1, 0, 0, 9, 0, 0, 1, 0, 0);
        add(0, 0, 0, 9, 0, 1, 1, 0, 0);
        add(0, 0, 0, 9, 0, 2, 1, 0, 0);
        add(0, 1, 0, 9, 0, 2, 0, 0, 0);
        add(0, 0, 0, 9, 0, 2, 0, 0, 0);
        add(0, 1, 0, 9, 0, 2, 0, 0, 0);
        add(1, 0, 0, 2, 0, 0, 1, 0, 0);
        add(0, 0, 0, 2, 0, 1, 1, 0, 0);
        add(0, 0, 0, 2, 0, 2, 1, 0, 0);
        add(0, 1, 0, 2, 0, 2, 0, 0, 0);
        add(0, 0, 0, 2, 0, 2, 0, 0, 0);
        c = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            apply(s);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            tests++;
            if ({out, busy, done, wrap_cnt} !== {e.o, e.b, e.d, e.w}) begin
                fails++;
                $display("FAIL stop c%0d: got o=%0d b=%b d=%b w=%0d want o=%0d b=%b d=%b w=%0d",
                         c, out, busy, done, wrap_cnt, e.o, e.b, e.d, e.w);
            end
            c++;
        end
    endtask

    task automatic test_limit0_busy_start();
        stim_t s;
        exp_t  e;
        int    c;
        add(1, 0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 7, 0, 0, 1, 0, 0);
        for (int k = 1; k <= 7; k++) add(1, 0, 0, 2, 1, 4'(k), 1, 0, 0);
        add(0, 0, 0, 2, 1, 7, 0, 1, 0);
        add(0, 0, 0, 2, 1, 7, 0, 0, 0);
        c = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            apply(s);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            tests++;
            if ({out, busy, done, wrap_cnt} !== {e.o, e.b, e.d, e.w}) begin
                fails++;
                $display("FAIL limit0_busy c%0d: got o=%0d b=%b d=%b w=%0d want o=%0d b=%b d=%b w=%0d",
                         c, out, busy, done, wrap_cnt, e.o, e.b, e.d, e.w);
            end
            c++;
        end
    endtask

    task automatic test_back_to_back();
        stim_t s;
        exp_t  e;
        int    c;
        add(1, 0, 0, 2, 0, 0, 1, 0, 0);
        add(0, 0, 0, 2, 0, 1, 1, 0, 0);
        add(0, 0, 0, 2, 0, 2, 1, 0, 0);
        add(0, 0, 0, 2, 0, 2, 0, 1, 0);
        add(1, 0, 0, 1, 0, 0, 1, 0, 0);
        add(0, 0, 0, 1, 0, 1, 1, 0, 0);
        add(0, 0, 0, 1, 0, 1, 0, 1, 0);
        add(0, 0, 0, 1, 0, 1, 0, 0, 0);
        add(1, 1, 0, 15, 0, 0, 1, 0, 0);
        for (int k = 1; k <= 15; k++) add(0, 0, 0, 15, 0, 4'(k), 1, 0, 0);
        add(0, 0, 0, 15, 0, 15, 0, 1, 0);
        add(0, 0, 0, 15, 0, 15, 0, 0, 0);
        c = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            apply(s);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            tests++;
            if ({out, busy, done, wrap_cnt} !== {e.o, e.b, e.d, e.w}) begin
                fails++;
                $display("FAIL back_to_back c%0d: got o=%0d b=%b d=%b w=%0d want o=%0d b=%b d=%b w=%0d",
                         c, out, busy, done, wrap_cnt, e.o, e.b, e.d, e.w);
            end
            c++;
        end
    endtask

`ifdef COUNT_SEQ_PAUSE_EN
    task automatic test_pause();
        stim_t s;
        exp_t  e;
        int    c;
        add(1, 0, 0, 6, 0, 0, 1, 0, 0);
        for (int k = 1; k <= 4; k++) add(0, 0, 0, 6, 0, 4'(k), 1, 0, 0);
        add(0, 0, 1, 6, 0, 4, 1, 0, 0);
        add(0, 0, 1, 6, 0, 4, 1, 0, 0);
        add(0, 0, 1, 6, 0, 4, 1, 0, 0);
        add(0, 0, 0, 6, 0, 4, 1, 0, 0);
        add(0, 0, 0, 6, 0, 5, 1, 0, 0);
        add(0, 0, 0, 6, 0, 6, 1, 0, 0);
        add(0, 0, 0, 6, 0, 6, 0, 1, 0);
        add(0, 0, 0, 6, 0, 6, 0, 0, 0);
        c = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            apply(s);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            tests++;
            if ({out, busy, done, wrap_cnt} !== {e.o, e.b, e.d, e.w}) begin
                fails++;
                $display("FAIL pause c%0d: got o=%0d b=%b d=%b w=%0d want o=%0d b=%b d=%b w=%0d",
                         c, out, busy, done, wrap_cnt, e.o, e.b, e.d, e.w);
            end
            c++;
        end
    endtask
`endif

    task automatic test_rst_midrun();
        stim_t s;
        exp_t  e;
        int    c;
        add(1, 0, 0, 1, 1, 0, 1, 0, 0);
        add(0, 0, 0, 1, 1, 1, 1, 0, 0);
        add(0, 0, 0, 1, 1, 0, 1, 1, 1);
        add(0, 0, 0, 1, 1, 1, 1, 0, 1);
        c = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            apply(s);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            tests++;
            if ({out, busy, done, wrap_cnt} !== {e.o, e.b, e.d, e.w}) begin
                fails++;
                $display("FAIL rst_run c%0d: got o=%0d b=%b d=%b w=%0d want o=%0d b=%b d=%b w=%0d",
                         c, out, busy, done, wrap_cnt, e.o, e.b, e.d, e.w);
            end
            c++;
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({out, busy, done, wrap_cnt} !== 14'd0) begin
            fails++;
            $display("FAIL rst_async: out=%0d busy=%b done=%b wrap=%0d want all 0",
                     out, busy, done, wrap_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        tests++;
        if ({out, busy, done, wrap_cnt} !== 14'd0) begin
            fails++;
            $display("FAIL rst_after: out=%0d busy=%b done=%b wrap=%0d want all 0",
                     out, busy, done, wrap_cnt);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_oneshot();
        test_reload();
        test_stop();
        test_limit0_busy_start();
        test_back_to_back();
`ifdef COUNT_SEQ_PAUSE_EN
        test_pause();
`endif
        test_rst_midrun();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
